// File: rtl/pattern_player.sv
// Pattern player for the memory tester: latches a target pattern (external or LFSR)
// and shows it one 4-bit digit at a time, MSB digit first, with blank gaps between digits.
module pattern_player #(
    parameter int          DIGITS      = 4,
    parameter int          SHOW_CYCLES = 8,
    parameter int          GAP_CYCLES  = 4,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                                      clock,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic                                      abort,
    input  logic                                      use_lfsr,
    input  logic [4*DIGITS-1:0]                       pattern_in,
    output logic [3:0]                                disp_nibble,
    output logic                                      disp_valid,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] digit_idx,
    output logic [4*DIGITS-1:0]                       target,
    output logic                                      busy,
    output logic                                      done
);
    localparam int W       = 4 * DIGITS;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int MAX_CNT = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 0) ? $clog2(MAX_CNT + 1) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [IDX_W-1:0] idx_next;
    logic [W-1:0]     target_next;
    logic [15:0]      lfsr;
    logic [3:0]       digits [DIGITS];

    // Free-running Fibonacci LFSR, x^16+x^14+x^13+x^11+1
    always_ff @(posedge clock) begin
        if (rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            digit_idx <= '0;
            target    <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            digit_idx <= idx_next;
            target    <= target_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        idx_next    = digit_idx;
        target_next = target;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next  = SHOW;
                    cnt_next    = '0;
                    idx_next    = '0;
                    target_next = use_lfsr ? W'(lfsr) : pattern_in;
                end
            end
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    cnt_next = '0;
                    if (digit_idx == LAST_IDX) begin
                        state_next = DONE;
                    end else if (GAP_CYCLES == 0) begin
                        idx_next = digit_idx + IDX_W'(1);
                    end else begin
                        state_next = GAP;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_next   = '0;
                    state_next = SHOW;
                    idx_next   = digit_idx + IDX_W'(1);
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
                idx_next   = '0;
            end
            default: state_next = IDLE;
        endcase
        // Abort overrides everything except IDLE; the latched target is kept.
        if (abort && state != IDLE) begin
            state_next = IDLE;
            cnt_next   = '0;
            idx_next   = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            digits[i] = target[W-1-4*i -: 4];
        end
    end

    assign busy        = (state != IDLE);
    assign disp_valid  = (state == SHOW);
    assign done        = (state == DONE);
    assign disp_nibble = disp_valid ? digits[digit_idx] : 4'h0;
endmodule

// File: tb/tb_pattern_player.sv
// Scoreboard bench for pattern_player: two instances (with and without gaps) share inputs;
// expected per-cycle traces are queued on accepted starts and popped by a negedge monitor.
module tb_pattern_player;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int SHOW = 3;
    localparam int GAP0 = 2;
    localparam int GAP1 = 0;

    logic        clock, rst, start, abort, use_lfsr;
    logic [15:0] pattern_in;
    logic [3:0]  nib_a, nib_b;
    logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    logic [1:0]  idx_a, idx_b;
    logic [15:0] target_a, target_b;

    pattern_player #(.DIGITS(4), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP0), .SEED(SEED)) dut_a (
        .clock(clock), .rst(rst), .start(start), .abort(abort), .use_lfsr(use_lfsr),
        .pattern_in(pattern_in), .disp_nibble(nib_a), .disp_valid(valid_a),
        .digit_idx(idx_a), .target(target_a), .busy(busy_a), .done(done_a)
    );

    pattern_player #(.DIGITS(4), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP1), .SEED(SEED)) dut_b (
        .clock(clock), .rst(rst), .start(start), .abort(abort), .use_lfsr(use_lfsr),
        .pattern_in(pattern_in), .disp_nibble(nib_b), .disp_valid(valid_b),
        .digit_idx(idx_b), .target(target_b), .busy(busy_b), .done(done_b)
    );

    typedef struct packed {
        logic       valid;
        logic [3:0] nib;
        logic [1:0] idx;
        logic       done;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] model_tgt0, model_tgt1, model_lfsr;
    logic        pend_rst, pend_abort, pend_start, pend_acc0, pend_acc1;
    logic [15:0] pend_t;
    logic        checking;
    int          checks, failures, cycle;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], ^(x & 16'hB400)};
    endfunction

    // Reference LFSR: value held here after an edge is what the DUT would latch at the next edge
    always @(posedge clock) begin
        model_lfsr <= rst ? SEED : lfsr_step(model_lfsr);
        cycle      <= cycle + 1;
    end

    task automatic push_trace(input int which, input int gap, input logic [15:0] t);
        exp_t        e;
        logic [15:0] sh;
        for (int d = 0; d < 4; d++) begin
            sh = t >> (4 * (3 - d));
            for (int c = 0; c < SHOW; c++) begin
                e = '{valid: 1'b1, nib: sh[3:0], idx: 2'(d), done: 1'b0};
                if (which == 0) q0.push_back(e); else q1.push_back(e);
            end
            if (d < 3) begin
                for (int c = 0; c < gap; c++) begin
                    e = '{valid: 1'b0, nib: 4'h0, idx: 2'(d), done: 1'b0};
                    if (which == 0) q0.push_back(e); else q1.push_back(e);
                end
            end
        end
        e = '{valid: 1'b0, nib: 4'h0, idx: 2'd3, done: 1'b1};
        if (which == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Waits for the next edge, commits the model effect of the inputs sampled there,
    // then drives the inputs for the following edge.
    task automatic apply_stimulus(input logic s, input logic a, input logic u,
                                  input logic [15:0] p, input logic r);
        @(posedge clock);
        #1;
        if (pend_rst) begin
            q0.delete(); q1.delete();
            model_tgt0 = '0; model_tgt1 = '0;
        end else if (pend_abort) begin
            q0.delete(); q1.delete();
        end else if (pend_start) begin
            if (pend_acc0) begin push_trace(0, GAP0, pend_t); model_tgt0 = pend_t; end
            if (pend_acc1) begin push_trace(1, GAP1, pend_t); model_tgt1 = pend_t; end
        end
        start = s; abort = a; use_lfsr = u; pattern_in = p; rst = r;
        pend_rst   = r;
        pend_abort = a;
        pend_start = s;
        pend_acc0  = (q0.size() == 0);
        pend_acc1  = (q1.size() == 0);
        pend_t     = u ? model_lfsr : p;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic check_output(input int which, input logic b, input logic v,
                                input logic [3:0] n, input logic [1:0] i, input logic d,
                                input logic [15:0] t);
        exp_t        e;
        logic        have;
        logic [15:0] et;
        have = 1'b0;
        e    = '0;
        if (which == 0) begin
            et = model_tgt0;
            if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        end else begin
            et = model_tgt1;
            if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        end
        checks++;
        if ({b, v, n, i, d, t} !== {have, e.valid, e.nib, e.idx, e.done, et}) begin
            failures++;
            $display("[TB] FAIL dut%0d_cycle%0d: got busy=%b valid=%b nib=%h idx=%0d done=%b target=%h, expected busy=%b valid=%b nib=%h idx=%0d done=%b target=%h",
                     which, cycle, b, v, n, i, d, t, have, e.valid, e.nib, e.idx, e.done, et);
        end
    endtask

    always @(negedge clock) begin
        if (checking) begin
            check_output(0, busy_a, valid_a, nib_a, idx_a, done_a, target_a);
            check_output(1, busy_b, valid_b, nib_b, idx_b, done_b, target_b);
        end
    end

    initial begin
        checks = 0; failures = 0; cycle = 0; checking = 1'b0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; use_lfsr = 1'b0; pattern_in = 16'h0;
        model_tgt0 = '0; model_tgt1 = '0;
        pend_rst = 1'b1; pend_abort = 1'b0; pend_start = 1'b0;
        pend_acc0 = 1'b0; pend_acc1 = 1'b0; pend_t = '0;
        @(posedge clock);
        #1;
        checking = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        idle(3);

        $display("[TB] plain playback 1234");
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'h1234, 1'b0);
        idle(25);

        $display("[TB] abort in gap after second digit");
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'h1234, 1'b0);
        idle(8);
        apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        idle(25);

        $display("[TB] start ignored while busy");
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'h1234, 1'b0);
        idle(6);
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'h5678, 1'b0);
        idle(25);

        $display("[TB] abort together with start in idle");
        apply_stimulus(1'b1, 1'b1, 1'b0, 16'hBEEF, 1'b0);
        idle(3);

        $display("[TB] lfsr start on fifth cycle after reset");
        apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        idle(4);
        apply_stimulus(1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0);
        idle(25);

        $display("[TB] reset mid playback");
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'h9ABC, 1'b0);
        idle(5);
        apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        idle(3);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 400; k++) begin
            apply_stimulus(($urandom % 4) == 0, ($urandom % 40) == 0, 1'($urandom % 2),
                           16'($urandom), ($urandom % 150) == 0);
        end
        idle(30);

        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d/%0d pending expected cycles, expected 0/0",
                     q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
